im_access_arbiter: RTL and testbench

- Sequences and shares the single-port synchronous instruction-memory block RAM (11-bit word address, 32-bit data, 1-cycle read latency) between two requesters.
- Requester 1 is the CPU fetch stage, which is read-only.
- Requester 2 is the loader/debug port, which can read or write, e.g. to boot-load user code and handler code.
- Converts byte PCs to word addresses, absorbs the RAM read latency, holds the instruction across fetch stalls, and flags illegal fetch addresses.

---
 rtl/im_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_im_access_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : im_access_arbiter
// Function : Shares one single-port instruction RAM between the CPU fetch stage
//            (read-only) and a loader/debug port (read/write). Optional grant
//            statistics are enabled with the macro IM_ACCESS_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module im_access_arbiter #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_3000,
  parameter int          AW            = 11,
  parameter int          MAX_FETCH_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_pc,
  input  logic          f_stall,
  output logic [31:0]   f_ins,
  output logic          f_valid,
  output logic          f_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic [31:0]   l_rdata,
  output logic          l_ack,
  output logic [AW-1:0] m_addr,
  output logic [3:0]    m_we,
  output logic [31:0]   m_din,
  input  logic [31:0]   m_dout
`ifdef IM_ACCESS_STATS_EN
  ,
  output logic [31:0]   stat_fetch,
  output logic [31:0]   stat_load,
  output logic [31:0]   stat_conflict
`endif
);

  localparam int                 c_run_w   = $clog2(MAX_FETCH_RUN + 1);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(MAX_FETCH_RUN);
  localparam logic [31:0]        c_depth   = 32'd1 << AW;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_frd  = 2'd1;
  localparam logic [1:0] c_st_lrd  = 2'd2;
  localparam logic [1:0] c_st_lwr  = 2'd3;

  logic [1:0]         r_state;
  logic [c_run_w-1:0] r_run;
  logic               r_f_bad;   // in-flight fetch was an illegal address
  logic               r_l_bad;   // in-flight loader access was an illegal address
  logic [31:0]        r_ins;
  logic               r_fv;
  logic               r_fe;

  logic [31:0] w_f_idx;
  logic [31:0] w_l_idx;
  logic        w_f_bad;
  logic        w_l_bad;
  logic        w_frd;
  logic        w_l_busy;
  logic        w_f_elig;
  logic        w_l_elig;
  logic        w_f_grant;
  logic        w_l_grant;
  logic        w_l_wr_ok;

  assign w_f_idx = (f_pc - BASE_ADDR) >> 2;
  assign w_l_idx = (l_addr - BASE_ADDR) >> 2;
  assign w_f_bad = (f_pc < BASE_ADDR) || (w_f_idx >= c_depth) || (f_pc[1:0] != 2'b00);
  assign w_l_bad = (l_addr < BASE_ADDR) || (w_l_idx >= c_depth) || (l_addr[1:0] != 2'b00);

  assign w_frd    = (r_state == c_st_frd);
  assign w_l_busy = (r_state == c_st_lrd) || (r_state == c_st_lwr);

  // Fetch output comes straight from the RAM in the cycle after the grant and
  // from the holding register afterwards, so a stall never depends on m_dout.
  assign f_valid = !reset && (w_frd || r_fv);
  assign f_err   = !reset && (w_frd ? r_f_bad : r_fe);
  assign f_ins   = reset ? 32'd0 : (w_frd ? (r_f_bad ? 32'd0 : m_dout) : r_ins);

  assign l_ack   = !reset && w_l_busy;
  assign l_rdata = (!reset && (r_state == c_st_lrd) && !r_l_bad) ? m_dout : 32'd0;

  assign w_f_elig  = !reset && f_req && !(f_valid && f_stall);
  assign w_l_elig  = !reset && l_req && !w_l_busy;
  assign w_l_grant = w_l_elig && (!w_f_elig || (r_run >= c_run_max));
  assign w_f_grant = w_f_elig && !w_l_grant;

  assign w_l_wr_ok = w_l_grant && l_we && !w_l_bad;
  assign m_we      = w_l_wr_ok ? 4'b1111 : 4'b0000;
  assign m_din     = w_l_wr_ok ? l_wdata : 32'd0;
  assign m_addr    = (w_l_grant && !w_l_bad) ? w_l_idx[AW-1:0] :
                     (w_f_grant && !w_f_bad) ? w_f_idx[AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_run   <= '0;
      r_f_bad <= 1'b0;
      r_l_bad <= 1'b0;
      r_ins   <= 32'd0;
      r_fv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      if (w_l_grant) begin
        r_state <= l_we ? c_st_lwr : c_st_lrd;
      end else if (w_f_grant) begin
        r_state <= c_st_frd;
      end else begin
        r_state <= c_st_idle;
      end
      r_f_bad <= w_f_bad;
      r_l_bad <= w_l_bad;
      r_ins   <= f_ins;
      r_fv    <= f_valid && f_stall;
      r_fe    <= f_err;
      if (w_l_grant || !l_req) begin
        r_run <= '0;
      end else if (w_f_grant && (r_run != c_run_max)) begin
        r_run <= r_run + c_run_w'(1);
      end
    end
  end

`ifdef IM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetch    <= 32'd0;
      stat_load     <= 32'd0;
      stat_conflict <= 32'd0;
    end else begin
      if (w_f_grant && (stat_fetch != 32'hFFFF_FFFF)) begin
        stat_fetch <= stat_fetch + 32'd1;
      end
      if (w_l_grant && (stat_load != 32'hFFFF_FFFF)) begin
        stat_load <= stat_load + 32'd1;
      end
      if (w_f_elig && w_l_elig && (stat_conflict != 32'hFFFF_FFFF)) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_im_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_access_arbiter
// Function : Scoreboard bench for im_access_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_stall, l_req, l_we;
  logic [31:0] f_pc, l_addr, l_wdata;
  logic [31:0] f_ins, l_rdata, m_din;
  logic [31:0] m_dout = 32'd0;
  logic        f_valid, f_err, l_ack;
  logic [10:0] m_addr;
  logic [3:0]  m_we;
`ifdef IM_ACCESS_STATS_EN
  logic [31:0] stat_fetch, stat_load, stat_conflict;
  logic [31:0] s_f0, s_l0, s_c0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:2047];
  logic        scramble = 1'b0;

  logic [32:0] fq[$];   // {err, ins}
  logic [32:0] lq[$];   // {is_read, rdata}
  logic        prev_hold = 1'b0;
  logic [31:0] last_ins  = 32'd0;
  logic        last_err  = 1'b0;

  im_access_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_pc(f_pc), .f_stall(f_stall),
    .f_ins(f_ins), .f_valid(f_valid), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .m_addr(m_addr), .m_we(m_we), .m_din(m_din), .m_dout(m_dout)
`ifdef IM_ACCESS_STATS_EN
    , .stat_fetch(stat_fetch), .stat_load(stat_load), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 3);
  endfunction

  function automatic logic f_illegal(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - 32'h0000_3000) >> 2;
    return (a < 32'h0000_3000) || (idx >= 32'd2048) || (a[1:0] != 2'b00);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-port synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (m_we != 4'b0000) mem[m_addr] <= m_din;
    m_dout <= scramble ? $urandom : mem[m_addr];
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (prev_hold) begin
      check_eq("f_hold_valid", 32'(f_valid), 32'd1);
      check_eq("f_hold_ins", f_ins, last_ins);
      check_eq("f_hold_err", 32'(f_err), 32'(last_err));
    end else if (f_valid) begin
      if (fq.size() == 0) begin
        check_eq("f_spurious_valid", 32'(f_valid), 32'd0);
      end else begin
        e = fq.pop_front();
        check_eq("f_ins", f_ins, e[31:0]);
        check_eq("f_err", 32'(f_err), 32'(e[32]));
        last_ins = e[31:0];
        last_err = e[32];
      end
    end
    prev_hold = f_valid && f_stall;
    if (l_ack) begin
      if (lq.size() == 0) begin
        check_eq("l_spurious_ack", 32'(l_ack), 32'd0);
      end else begin
        e = lq.pop_front();
        if (e[32]) check_eq("l_rdata", l_rdata, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs [4];
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    reset = 1'b1; f_req = 1'b0; f_pc = 32'd0; f_stall = 1'b0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;
    repeat (2) step();
    @(negedge clk);
    check_eq("rst_f_ins", f_ins, 32'd0);
    check_eq("rst_f_valid", 32'(f_valid), 32'd0);
    check_eq("rst_f_err", 32'(f_err), 32'd0);
    check_eq("rst_l_rdata", l_rdata, 32'd0);
    check_eq("rst_l_ack", 32'(l_ack), 32'd0);
    check_eq("rst_m_we", 32'(m_we), 32'd0);
    check_eq("rst_m_addr", 32'(m_addr), 32'd0);
    check_eq("rst_m_din", m_din, 32'd0);
    step(); reset = 1'b0;

    // loader write then fetch of the same word
    step(); l_req = 1'b1; l_we = 1'b1; l_addr = 32'h3000; l_wdata = 32'h2408_0005;
    lq.push_back({1'b0, 32'd0});
    @(negedge clk);
    check_eq("lw_m_we", 32'(m_we), 32'hF);
    check_eq("lw_m_addr", 32'(m_addr), 32'd0);
    check_eq("lw_m_din", m_din, 32'h2408_0005);
    step(); l_req = 1'b0; l_we = 1'b0;
    step(); f_req = 1'b1; f_pc = 32'h3000;
    fq.push_back({1'b0, 32'h2408_0005});
    @(negedge clk);
    check_eq("f1_m_we", 32'(m_we), 32'd0);
    step(); f_req = 1'b0;
    step();
    @(negedge clk);
    check_eq("f1_valid_drop", 32'(f_valid), 32'd0);

    // fetch held across a 3-cycle stall while the RAM output wanders
    step(); f_req = 1'b1; f_pc = 32'h3004;
    fq.push_back({1'b0, pat(1)});
    step(); f_stall = 1'b1; f_pc = 32'h3008; scramble = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_no_fetch", 32'(m_addr == 11'd2), 32'd0);
      check_eq("stall_m_we", 32'(m_we), 32'd0);
      if (k < 2) step();
    end
    step(); f_stall = 1'b0; scramble = 1'b0;
    fq.push_back({1'b0, pat(2)});
    step(); f_req = 1'b0;
    step();
    @(negedge clk);
    check_eq("f2_valid_drop", 32'(f_valid), 32'd0);

    // illegal fetch PCs, plus the last legal word
    pcs[0] = 32'h2FFC; pcs[1] = 32'h3002; pcs[2] = 32'h5000; pcs[3] = 32'h4FFC;
    for (int k = 0; k < 4; k++) begin
      step(); f_req = 1'b1; f_pc = pcs[k];
      fq.push_back(f_illegal(pcs[k]) ? {1'b1, 32'd0} : {1'b0, pat(2047)});
      @(negedge clk);
      check_eq("ill_m_we", 32'(m_we), 32'd0);
      if (!f_illegal(pcs[k])) check_eq("last_word_addr", 32'(m_addr), 32'd2047);
    end
    step(); f_req = 1'b0;

    // illegal loader read and write
    step(); l_req = 1'b1; l_we = 1'b0; l_addr = 32'h2000;
    lq.push_back({1'b1, 32'd0});
    @(negedge clk);
    check_eq("lill_rd_we", 32'(m_we), 32'd0);
    step(); l_req = 1'b0;
    step(); l_req = 1'b1; l_we = 1'b1; l_addr = 32'h3001; l_wdata = 32'hDEAD_BEEF;
    lq.push_back({1'b0, 32'd0});
    @(negedge clk);
    check_eq("lill_wr_we", 32'(m_we), 32'd0);
    step(); l_req = 1'b0; l_we = 1'b0;

    // both requesters held: 4 fetches then 1 loader read, repeating
    step();
`ifdef IM_ACCESS_STATS_EN
    @(negedge clk);
    s_f0 = stat_fetch; s_l0 = stat_load; s_c0 = stat_conflict;
`endif
    for (int c = 0; c < 15; c++) begin
      step();
      f_req = 1'b1; f_pc = 32'h3010; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h3020;
      if (c % 5 == 4) lq.push_back({1'b1, pat(8)});
      else            fq.push_back({1'b0, pat(4)});
      @(negedge clk);
      check_eq("arb_addr", 32'(m_addr), (c % 5 == 4) ? 32'd8 : 32'd4);
    end
    step(); f_req = 1'b0; l_req = 1'b0;
`ifdef IM_ACCESS_STATS_EN
    @(negedge clk);
    check_eq("stat_fetch", stat_fetch - s_f0, 32'd12);
    check_eq("stat_load", stat_load - s_l0, 32'd3);
    check_eq("stat_conflict", stat_conflict - s_c0, 32'd13);
`endif
    step(); step();

    // reset in the cycle after a loader read grant
    step(); l_req = 1'b1; l_we = 1'b0; l_addr = 32'h3008;
    @(negedge clk);
    check_eq("rst5_grant_addr", 32'(m_addr), 32'd2);
    step(); reset = 1'b1; l_req = 1'b0;
    @(negedge clk);
    check_eq("rst5_no_ack", 32'(l_ack), 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check_eq("rst5_f_ins", f_ins, 32'd0);
    check_eq("rst5_f_valid", 32'(f_valid), 32'd0);
    check_eq("rst5_f_err", 32'(f_err), 32'd0);
    check_eq("rst5_l_rdata", l_rdata, 32'd0);
    check_eq("rst5_l_ack", 32'(l_ack), 32'd0);
    check_eq("rst5_m_we", 32'(m_we), 32'd0);
    check_eq("rst5_m_addr", 32'(m_addr), 32'd0);
    check_eq("rst5_m_din", m_din, 32'd0);
    step(); step();

    check_eq("fetch_sb_empty", 32'(fq.size()), 32'd0);
    check_eq("load_sb_empty", 32'(lq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
